enet_gmii_tx_arbiter: RTL

ENET_GMII_TX_ARBITER -- requirements
Module: enet_gmii_tx_arbiter

---
 rtl/enet_gmii_tx_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/enet_gmii_tx_arbiter.sv
// Two-requester GMII transmit arbiter: round-robin frame grant, preamble/SFD
// insertion, underrun/overlength abort with drain, and inter-frame gap timing.
module enet_gmii_tx_arbiter #(
    parameter int IFG_CYCLES = 12,
    parameter int MAX_BYTES  = 1518
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_enable,
    input  logic       s0_valid,
    input  logic [7:0] s0_data,
    input  logic       s0_last,
    output logic       s0_ready,
    input  logic       s1_valid,
    input  logic [7:0] s1_data,
    input  logic       s1_last,
    output logic       s1_ready,
    output logic       gmii_tx_en,
    output logic       gmii_tx_er,
    output logic [7:0] gmii_txd,
    output logic       frame_done,
    output logic       frame_err,
    output logic       grant_id
);
    typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, DRAIN, IFG} state_t;

    localparam logic [13:0] MAX_W = 14'(MAX_BYTES);
    localparam logic [7:0]  IFG_W = 8'(IFG_CYCLES);

    state_t      state_q;
    logic [2:0]  pre_cnt_q;
    logic [7:0]  ifg_cnt_q;
    logic [13:0] byte_cnt_q;
    logic        prev_q;
    logic        grant_q;
    logic        tx_en_q;
    logic        tx_er_q;
    logic [7:0]  txd_q;
    logic        done_q;
    logic        err_q;

    logic        pick_d;
    logic        sel_valid;
    logic        sel_last;
    logic [7:0]  sel_data;
    logic        xfer_phase;
    logic        abort;

    // On a tie the port that did not win last time gets the frame.
    assign pick_d     = (s0_valid && s1_valid) ? ~prev_q : s1_valid;
    assign sel_valid  = grant_q ? s1_valid : s0_valid;
    assign sel_last   = grant_q ? s1_last  : s0_last;
    assign sel_data   = grant_q ? s1_data  : s0_data;
    assign xfer_phase = (state_q == SFD) || (state_q == DATA) || (state_q == DRAIN);
    // A byte offered once the counter has hit the limit is swallowed as an abort.
    assign abort      = !sel_valid || (byte_cnt_q == MAX_W);

    assign s0_ready   = xfer_phase && !grant_q;
    assign s1_ready   = xfer_phase &&  grant_q;
    assign gmii_tx_en = tx_en_q;
    assign gmii_tx_er = tx_er_q;
    assign gmii_txd   = txd_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;
    assign grant_id   = grant_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pre_cnt_q  <= '0;
            ifg_cnt_q  <= '0;
            byte_cnt_q <= '0;
            prev_q     <= 1'b1;
            grant_q    <= 1'b0;
            tx_en_q    <= 1'b0;
            tx_er_q    <= 1'b0;
            txd_q      <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            tx_en_q <= 1'b0;
            tx_er_q <= 1'b0;
            txd_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (tx_enable && (s0_valid || s1_valid)) begin
                        grant_q    <= pick_d;
                        prev_q     <= pick_d;
                        byte_cnt_q <= '0;
                        pre_cnt_q  <= '0;
                        tx_en_q    <= 1'b1;
                        txd_q      <= 8'h55;
                        state_q    <= PRE;
                    end
                end
                PRE: begin
                    tx_en_q <= 1'b1;
                    if (pre_cnt_q == 3'd6) begin
                        txd_q   <= 8'hD5;
                        state_q <= SFD;
                    end else begin
                        txd_q     <= 8'h55;
                        pre_cnt_q <= pre_cnt_q + 3'd1;
                    end
                end
                SFD, DATA: begin
                    tx_en_q <= 1'b1;
                    if (abort) begin
                        tx_er_q   <= 1'b1;
                        err_q     <= 1'b1;
                        ifg_cnt_q <= '0;
                        state_q   <= (sel_valid && sel_last) ? IFG : DRAIN;
                    end else begin
                        txd_q      <= sel_data;
                        byte_cnt_q <= byte_cnt_q + 14'd1;
                        if (sel_last) begin
                            done_q    <= 1'b1;
                            ifg_cnt_q <= '0;
                            state_q   <= IFG;
                        end else begin
                            state_q <= DATA;
                        end
                    end
                end
                DRAIN: begin
                    if (sel_valid && sel_last) begin
                        ifg_cnt_q <= '0;
                        state_q   <= IFG;
                    end
                end
                IFG: begin
                    // Entered while the final byte is still on the wire.
                    if (ifg_cnt_q == IFG_W) begin
                        state_q <= IDLE;
                    end else begin
                        ifg_cnt_q <= ifg_cnt_q + 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
